// File: rtl/pipelined_channel_mux.sv
// N_CH-way channel mux with a registered valid/ready output stage; fixed or round-robin selection.
// Optional MUX_PARITY_EN adds a registered XOR-parity output alongside out_data.
module pipelined_channel_mux #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MUX_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [SEL_W-1:0]        out_ch
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_pick;
  logic [SEL_W-1:0] chosen;
  logic             rr_found;
  logic             fixed_ok;
  logic             grant_ok;
  logic             slot_free;
  logic [WIDTH-1:0] chosen_data;
  int               rr_idx;

  // Scan starts one past the last round-robin winner and wraps.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
      if (!rr_found && in_valid[rr_idx[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    fixed_ok    = ({1'b0, sel} < (SEL_W+1)'(N_CH)) && in_valid[sel];
    chosen      = mode ? rr_pick : sel;
    grant_ok    = mode ? rr_found : fixed_ok;
    slot_free   = !out_valid || out_ready;
    chosen_data = in_data[chosen*WIDTH +: WIDTH];
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = slot_free && grant_ok && (chosen == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      rr_ptr     <= SEL_W'(N_CH - 1);
`ifdef MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (slot_free && grant_ok) begin
      out_valid  <= 1'b1;
      out_data   <= chosen_data;
      out_ch     <= chosen;
`ifdef MUX_PARITY_EN
      out_parity <= ^chosen_data;
`endif
      if (mode) rr_ptr <= chosen;
    end else if (out_valid && out_ready) begin
      // Word consumed with nothing to replace it; data and channel id hold.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_channel_mux.sv
// Randomized bench for pipelined_channel_mux with a queue-free behavioural model and directed literal checks.
module tb_pipelined_channel_mux;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;
`ifdef MUX_PARITY_EN
  logic            out_parity;
`endif

  pipelined_channel_mux #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  // Reference state: the word the output register should hold and the last RR winner.
  bit      m_valid = 0;
  int      m_data = 0;
  int      m_ch = 0;
  int      m_rr = N - 1;
  bit      m_par = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pick(output bit ok, output int ch);
    ok = 0;
    ch = 0;
    if (!mode) begin
      ch = int'(sel);
      ok = (ch < N) && in_valid[ch];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!ok && in_valid[c]) begin
          ok = 1;
          ch = c;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ready();
    bit ok;
    int ch;
    pick(ok, ch);
    if ((!m_valid || out_ready) && ok) return N'(1) << ch;
    return '0;
  endfunction

  always @(posedge clk) begin
    bit ok;
    int ch;
    if (reset) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_rr = N - 1; m_par = 0;
    end else begin
      pick(ok, ch);
      if ((!m_valid || out_ready) && ok) begin
        m_valid = 1;
        m_data  = int'(in_data[ch*W +: W]);
        m_ch    = ch;
        m_par   = ^in_data[ch*W +: W];
        if (mode) m_rr = ch;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_out_valid", 64'(out_valid), 64'(m_valid));
      check("model_out_data", 64'(out_data), 64'(unsigned'(m_data)));
      check("model_out_ch", 64'(out_ch), 64'(m_ch));
      check("model_in_ready", 64'(in_ready), 64'(exp_ready()));
`ifdef MUX_PARITY_EN
      check("model_out_parity", 64'(out_parity), 64'(m_par));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pow2_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(1) << i;
  endtask

  initial begin
    reset = 1; mode = 0; sel = '0; in_valid = '0; out_ready = 0;
    set_pow2_data();
    step(); step();
    started = 1;
    reset = 0;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", 64'(out_data), 64'd0);
    check("reset_ch", 64'(out_ch), 64'd0);

    // Fixed select sweep
    in_valid = 8'hFF; out_ready = 1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      #1;
      check("fix_in_ready", 64'(in_ready), 64'(1) << s);
      step();
      check("fix_data", 64'(out_data), 64'(1) << s);
      check("fix_ch", 64'(out_ch), 64'(s));
    end

    // Stall holds the word
    sel = 3; step();
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      step();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'd8);
    end
    sel = 2; out_ready = 1;
    #1;
    check("unstall_in_ready", 64'(in_ready), 64'h4);
    step();
    check("unstall_data", 64'(out_data), 64'd4);

    // Round-robin from reset
    reset = 1; mode = 1; step();
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rr_ch", 64'(out_ch), 64'(k % N));
      check("rr_data", 64'(out_data), 64'(1) << (k % N));
    end

    // Sparse round-robin, then drain
    in_valid = 8'b0010_0100;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_sparse_ch", 64'(out_ch), (k % 2 == 0) ? 64'd2 : 64'd5);
    end
    in_valid = '0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Fixed select on an idle channel
    mode = 0; sel = 6; in_valid = 8'hBF;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd0);
    step();
    check("idle_valid", 64'(out_valid), 64'd0);
    in_valid = 8'hFF;
    step();
    check("idle_then_data", 64'(out_data), 64'd64);

    // Reset drops a stalled word
    out_ready = 0; step();
    reset = 1; step();
    reset = 0;
    check("rst_stall_valid", 64'(out_valid), 64'd0);
    check("rst_stall_data", 64'(out_data), 64'd0);
    check("rst_stall_ch", 64'(out_ch), 64'd0);
    mode = 1; out_ready = 1; in_valid = 8'hFF;
    in_data[0 +: W] = 32'h7;
    step();
    check("rst_rr_ch", 64'(out_ch), 64'd0);
    check("rst_rr_data", 64'(out_data), 64'd7);
`ifdef MUX_PARITY_EN
    check("parity_7", 64'(out_parity), 64'd1);
`endif

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel = SW'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0: in_valid = '0;
        1: in_valid = 8'hFF;
        default: in_valid = N'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      step();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipelined_channel_mux.md
Name: pipelined_channel_mux

Overview:
Parametrised successor to the 8x32 combinational select mux. It selects one of N_CH input channels and presents the result through a registered output stage with valid/ready handshaking. Two selection modes: fixed (external sel) and round-robin among valid channels. It sits between ALU result producers and the writeback/result bus, where producers may stall and the consumer may backpressure.

Parameters:
WIDTH, 32, data width per channel in bits
N_CH, 8, number of input channels (2..16)
SEL_W, 3, select/channel-id width; must equal clog2(N_CH)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  N_CH*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel data valid
in_ready  output  N_CH  per-channel accept; transfer on channel i when in_valid[i] && in_ready[i]
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data this cycle
out_ch  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset (reset high at an edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1, so that channel 0 has first round-robin priority. Reset takes priority over every other event; a word held in the output register is dropped.
- slot_free = !out_valid || out_ready. Combinational.
- Fixed mode: chosen = sel. grant_ok = (sel < N_CH) && in_valid[sel]. An out-of-range sel never grants.
- Round-robin mode: chosen = first i with in_valid[i] set, scanning rr_ptr+1, rr_ptr+2, ... modulo N_CH, with wrap-around. grant_ok = |in_valid.
- in_ready[i] = slot_free && grant_ok && (i == chosen). At most one bit is set. Combinational from mode, sel, in_valid, out_valid and out_ready; it never depends on in_data.
- On an edge with slot_free && grant_ok:
  - out_data <= channel chosen;
  - out_ch <= chosen;
  - out_valid <= 1;
  - in round-robin mode only, rr_ptr <= chosen.
- On an edge with out_valid && out_ready && !grant_ok: out_valid <= 0. out_data and out_ch hold their values.
- Otherwise all registers hold. While out_valid && !out_ready, out_data and out_ch stay stable.
- Latency is 1 cycle from input handshake to out_valid. Full throughput is one word per cycle when out_ready is held high.
- A mode change takes effect in the same cycle. rr_ptr is retained across fixed-mode periods and is not updated by fixed-mode grants.
- Only the single chosen channel is granted per cycle. Other valid channels wait with in_ready=0.

Optional Feature:
MUX_PARITY_EN:
- Defined: adds output port out_parity (1 bit), equal to the registered XOR-reduction of the word loaded into out_data. It is loaded on the same edge as out_data, reset to 0, and held under backpressure.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Fixed mode, in_valid=8'hFF, channel i data=2**i, out_ready=1, sel stepped 0..7 one per cycle -> out_data=2**sel and out_ch=sel one cycle later; in_ready=1<<sel each cycle.
- Fixed mode, sel=3, out_ready=0 for 4 cycles, then 1 -> out_valid=1 with out_data=8 held stable throughout the stall; in_ready=0 while stalled; a new word is accepted in the cycle out_ready rises.
- Round-robin mode, all valid, out_ready=1, starting from reset -> out_ch sequence 0,1,2,...,7,0,1; out_data=2**out_ch each time.
- Round-robin mode, in_valid=8'b0010_0100 -> out_ch sequence 2,5,2,5. Then drop in_valid to 0 -> out_valid falls to 0 the cycle after the last word is accepted.
- Fixed mode, sel=6 with in_valid[6]=0, other channels valid -> in_ready=0 and out_valid stays 0. Set in_valid[6]=1 -> out_data=64 next cycle.
- Reset asserted for one cycle while out_valid=1 and out_ready=0 -> after the edge out_valid=0, out_data=0, out_ch=0; the next round-robin grant is channel 0. With MUX_PARITY_EN, channel data 32'h7 -> out_parity=1.
